// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN enables a short IDLE->FIX path for trivial operands.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [RD_W-1:0] rd_in,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            we_out
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // CALC  | XLEN iteration steps, counter XLEN-1..0
  // FIX   | sign correction and boundary overrides
  // DONE  | one-cycle done / write-back pulse
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [RD_W-1:0]   r_rd;
  logic              r_a_neg, r_b_neg, r_div0, r_ovf;
  logic [XLEN-1:0]   r_dividend;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplr;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_result;
  logic [RD_W-1:0]   r_rd_out;

  logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
  assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
  assign w_a_mag    = w_a_neg ? (-rs1_val) : rs1_val;
  assign w_b_mag    = w_b_neg ? (-rs2_val) : rs2_val;
  assign w_div0     = w_is_div && (rs2_val == '0);
  assign w_ovf      = w_is_div && ~funct3[0] && (rs1_val == SMIN) && (rs2_val == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_short;
  assign w_short = w_div0 | w_ovf | (~w_is_div & ((rs1_val == '0) | (rs2_val == '0)));
`endif

  // Restoring divide: divisor lives in the low half of r_mcand, dividend shifts out of r_mplr.
  assign w_rem_sh = {r_rem, r_mplr[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_mcand[XLEN-1:0]};

  assign w_prod = (r_a_neg ^ r_b_neg) ? (-r_acc) : r_acc;
  assign w_quo  = (r_a_neg ^ r_b_neg) ? (-r_mplr) : r_mplr;
  assign w_rem  = r_a_neg ? (-r_rem) : r_rem;

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = r_div0 ? '1 : (r_ovf ? SMIN : w_quo);
      default:                w_fix_res = r_div0 ? r_dividend : (r_ovf ? '0 : w_rem);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
        w_state_nxt = w_short ? S_FIX : S_CALC;
`else
        w_state_nxt = S_CALC;
`endif
      end
      S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dividend <= '0;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt      <= CW'(XLEN-1);
          r_f3       <= funct3;
          r_rd       <= rd_in;
          r_a_neg    <= w_a_neg;
          r_b_neg    <= w_b_neg;
          r_div0     <= w_div0;
          r_ovf      <= w_ovf;
          r_dividend <= rs1_val;
          r_mcand    <= {{XLEN{1'b0}}, (w_is_div ? w_b_mag : w_a_mag)};
          r_mplr     <= w_is_div ? w_a_mag : w_b_mag;
          r_acc      <= '0;
          r_rem      <= '0;
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_f3[2]) begin
            if (!w_diff[XLEN]) begin
              r_rem  <= w_diff[XLEN-1:0];
              r_mplr <= {r_mplr[XLEN-2:0], 1'b1};
            end else begin
              r_rem  <= w_rem_sh[XLEN-1:0];
              r_mplr <= {r_mplr[XLEN-2:0], 1'b0};
            end
          end else begin
            if (r_mplr[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_rd_out <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign rd_out = r_rd_out;
  assign we_out = done && (r_rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; expected latencies follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;
  localparam int LAT_LONG = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SHORT = 2;
`else
  localparam int LAT_SHORT = 34;
`endif

  logic        clk, reset_n, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        ready, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .ready(ready), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          due;
  } exp_t;
  exp_t  sb[$];
  string sb_nm[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        check({nm, ".result"}, result, e.res);
        check({nm, ".rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
        check({nm, ".we_out"}, {31'd0, we_out}, {31'd0, e.we});
        check({nm, ".done_cycle"}, cyc, e.due);
      end
    end
    if (we_out && !done) begin
      n_checks++;
      n_fail++;
      $display("FAIL we_without_done: got we_out=1 done=0, expected we_out=0");
    end
  end

  // Drives one request once ready; done is expected lat cycles after the start cycle.
  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.ready_timeout: got ready=0, expected 1", nm);
      return;
    end
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
    e.res = exp; e.rd = rd; e.we = (rd != 5'd0); e.due = cyc + lat;
    sb.push_back(e);
    sb_nm.push_back(nm);
    @(posedge clk);
    #1;
    start = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; rd_in = 5'd31; funct3 = 3'b111;
    check({nm, ".ready_busy"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset_n = 1'b0; start = 1'b0; funct3 = 3'b000;
    rs1_val = '0; rs2_val = '0; rd_in = '0;
    #12;
    check("reset.ready",  {31'd0, ready},  32'd1);
    check("reset.done",   {31'd0, done},   32'd0);
    check("reset.result", result,          32'd0);
    check("reset.rd_out", {27'd0, rd_out}, 32'd0);
    check("reset.we_out", {31'd0, we_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("mul_7x-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_LONG);
    issue("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, LAT_LONG);
    issue("mulh_-1x-1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, LAT_LONG);
    issue("mulhsu_-1x2",   3'b010, 32'hFFFF_FFFF, 32'd2,          5'd3,  32'hFFFF_FFFF, LAT_LONG);
    issue("div_-7/2",      3'b100, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD, LAT_LONG);
    issue("rem_-7/2",      3'b110, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, LAT_LONG);
    issue("divu_100/7",    3'b101, 32'd100,        32'd7,          5'd8,  32'd14,        LAT_LONG);
    issue("remu_100/7",    3'b111, 32'd100,        32'd7,          5'd9,  32'd2,         LAT_LONG);
    issue("divu_5/0",      3'b101, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, LAT_SHORT);
    issue("rem_5/0",       3'b110, 32'd5,          32'd0,          5'd11, 32'd5,         LAT_SHORT);
    issue("div_-5/0",      3'b100, 32'hFFFF_FFFB, 32'd0,          5'd12, 32'hFFFF_FFFF, LAT_SHORT);
    issue("rem_-5/0",      3'b110, 32'hFFFF_FFFB, 32'd0,          5'd13, 32'hFFFF_FFFB, LAT_SHORT);
    issue("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, LAT_SHORT);
    issue("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         LAT_SHORT);
    issue("divu_min/max",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         LAT_LONG);
    issue("remu_min/max",  3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, LAT_LONG);
    issue("div_9/0",       3'b100, 32'd9,          32'd0,          5'd18, 32'hFFFF_FFFF, LAT_SHORT);
    issue("mul_0x9_rd0",   3'b000, 32'd0,          32'd9,          5'd0,  32'd0,         LAT_SHORT);

    // Start re-pulsed while busy must be ignored.
    issue("mul_3x4",       3'b000, 32'd3,          32'd4,          5'd7,  32'd12,        LAT_LONG);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd3; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation aborts silently.
    issue("divu_aborted",  3'b101, 32'd1000,       32'd10,         5'd3,  32'd100,       LAT_LONG);
    repeat (9) @(negedge clk);
    sb.delete();
    sb_nm.delete();
    reset_n = 1'b0;
    #1;
    check("abort.ready",  {31'd0, ready},  32'd1);
    check("abort.done",   {31'd0, done},   32'd0);
    check("abort.result", result,          32'd0);
    check("abort.we_out", {31'd0, we_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("mulhu_2^32_rd0", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'd1,        LAT_LONG);
    issue("mul_-1x-1",      3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd1,       LAT_LONG);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending ops, expected 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
